// File: rtl/subkey_sequencer.sv
// Latches sixteen 48-bit round subkeys on start and presents them one per
// accepted transfer, forward or reversed, through a valid/ready handshake.
module subkey_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] subkey1,
    input  logic [47:0] subkey2,
    input  logic [47:0] subkey3,
    input  logic [47:0] subkey4,
    input  logic [47:0] subkey5,
    input  logic [47:0] subkey6,
    input  logic [47:0] subkey7,
    input  logic [47:0] subkey8,
    input  logic [47:0] subkey9,
    input  logic [47:0] subkey10,
    input  logic [47:0] subkey11,
    input  logic [47:0] subkey12,
    input  logic [47:0] subkey13,
    input  logic [47:0] subkey14,
    input  logic [47:0] subkey15,
    input  logic [47:0] subkey16,
    input  logic        start,
    input  logic        decrypt,
    input  logic        abort,
    input  logic        key_ready,
    output logic [47:0] round_key,
    output logic        key_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [47:0] w_sub [16];
    logic [47:0] r_keys [16];
    logic        r_decrypt;
    logic [3:0]  r_idx;
    logic [47:0] r_key;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  w_idx_nxt;
    logic [47:0] w_key_nxt;
    logic        w_valid_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_load;

    // Storage slot for a sequence position; reverse order walks 16..1.
    function automatic logic [3:0] slot_of(input logic dec, input logic [3:0] pos);
        return dec ? (4'd15 - pos) : pos;
    endfunction

    assign w_sub[0]  = subkey1;
    assign w_sub[1]  = subkey2;
    assign w_sub[2]  = subkey3;
    assign w_sub[3]  = subkey4;
    assign w_sub[4]  = subkey5;
    assign w_sub[5]  = subkey6;
    assign w_sub[6]  = subkey7;
    assign w_sub[7]  = subkey8;
    assign w_sub[8]  = subkey9;
    assign w_sub[9]  = subkey10;
    assign w_sub[10] = subkey11;
    assign w_sub[11] = subkey12;
    assign w_sub[12] = subkey13;
    assign w_sub[13] = subkey14;
    assign w_sub[14] = subkey15;
    assign w_sub[15] = subkey16;

    // Next-state and next-output decode; outputs are precomputed so they leave registers.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_key_nxt   = r_key;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = 4'd0;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                    // First key comes straight from the inputs being latched this edge.
                    w_key_nxt   = w_sub[slot_of(decrypt, 4'd0)];
                end else begin
                    w_idx_nxt   = 4'd0;
                    w_valid_nxt = 1'b0;
                    w_key_nxt   = 48'd0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 4'd0;
                    w_valid_nxt = 1'b0;
                    w_key_nxt   = 48'd0;
                end else if (key_ready) begin
                    if (r_idx == 4'd15) begin
                        w_state_nxt = ST_DONE;
                        w_idx_nxt   = 4'd0;
                        w_valid_nxt = 1'b0;
                        w_key_nxt   = 48'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_key_nxt   = r_keys[slot_of(r_decrypt, r_idx + 4'd1)];
                    end
                end else begin
                    w_idx_nxt   = r_idx;
                    w_key_nxt   = r_key;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 4'd0;
                w_valid_nxt = 1'b0;
                w_key_nxt   = 48'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 4'd0;
                w_valid_nxt = 1'b0;
                w_key_nxt   = 48'd0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_key   <= 48'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Subkey and order snapshot taken only when a sequence is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decrypt <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_keys[i] <= 48'd0;
            end
        end else if (w_load) begin
            r_decrypt <= decrypt;
            for (int i = 0; i < 16; i++) begin
                r_keys[i] <= w_sub[i];
            end
        end else begin
            r_decrypt <= r_decrypt;
        end
    end

    assign round_key = r_key;
    assign key_valid = r_valid;
    assign round_idx = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/subkey_sequencer.md
SUBKEY_SEQUENCER -- requirements
Module: subkey_sequencer

Interface
REQ-001 The block SHALL have no parameters; widths and round count (16) are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 subkey1 .. subkey16  input  48 each  parallel subkeys from the key schedule, bit-numbered [1:48].
REQ-005 start  input  1  request to latch all subkeys and begin a 16-round sequence.
REQ-006 decrypt  input  1  order select, sampled with start: 0 = subkey1..16, 1 = subkey16..1.
REQ-007 abort  input  1  synchronous cancel of an in-progress sequence.
REQ-008 key_ready  input  1  round engine accepts round_key this cycle.
REQ-009 round_key  output  48  current subkey, [1:48].
REQ-010 key_valid  output  1  round_key and round_idx are valid.
REQ-011 round_idx  output  4  position in sequence, 0..15 (round number minus 1, independent of order).
REQ-012 busy  output  1  high in RUN and DONE states.
REQ-013 done  output  1  single-cycle pulse after the 16th transfer.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, encoded in one state register.
REQ-015 In IDLE with start=1, the block SHALL latch all sixteen subkeys and decrypt into internal registers, clear the position counter to 0, and enter RUN on that edge.
REQ-016 First-key latency SHALL be one cycle: key_valid=1 with the first key in the cycle after start is sampled.
REQ-017 In RUN, round_key SHALL be latched subkey(idx+1) when decrypt=0 and latched subkey(16-idx) when decrypt=1, where idx = round_idx.
REQ-018 A transfer SHALL occur on each edge where key_valid=1 and key_ready=1; it advances round_idx by 1.
REQ-019 While key_valid=1 and key_ready=0, round_key and round_idx SHALL hold stable.
REQ-020 key_ready SHALL NOT be required for valid to assert: valid does not depend combinationally on ready.
REQ-021 The transfer at round_idx=15 SHALL move the FSM to DONE, deassert key_valid, and wrap round_idx to 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 start SHALL be ignored in RUN and DONE; back-to-back sequences need start in IDLE.
REQ-024 Changes on subkey1..16 or decrypt after latching SHALL NOT affect the sequence in progress.
REQ-025 abort=1 in RUN or DONE SHALL force IDLE on the next edge: key_valid=0, round_idx=0, no done pulse.
REQ-026 abort=1 in IDLE SHALL take priority over start: no sequence begins.
REQ-027 Sustained key_ready=1 SHALL yield 16 keys in 16 consecutive cycles; done SHALL fire 17 cycles after start is sampled.

Reset
REQ-028 When rst=1, regardless of clk, the block SHALL enter IDLE with key_valid=0, done=0, busy=0, round_idx=0 and round_key=0; latched subkeys and the order bit SHALL be cleared to 0.
REQ-029 Deassertion of rst mid-sequence SHALL NOT resume the sequence; a new start is required.

Verification
REQ-030 Bench SHALL apply the schedule of key 133457799BBCDFF1 with decrypt=0, start, and key_ready=1 -> cycle+1: round_key=1B02EFFC7072, round_idx=0; cycle+16: round_key=CB3D8B0E17F5, round_idx=15; cycle+17: done=1, key_valid=0.
REQ-031 Bench SHALL apply the same key with decrypt=1 -> first key CB3D8B0E17F5 at idx 0, last key 1B02EFFC7072 at idx 15.
REQ-032 Bench SHALL drive subkeyN = N (hex), with key_ready low for 3 cycles at idx 4 -> round_key=000000000005 held for 4 cycles, then the sequence continues with 6.
REQ-033 Bench SHALL assert abort at idx 7 -> next cycle IDLE, key_valid=0, round_idx=0, no done pulse; a later start restarts at subkey1.
REQ-034 Bench SHALL assert rst at idx 10 -> outputs zero immediately (before the next edge); after release, start with subkey values changed during RUN -> the new values are used.
REQ-035 Bench SHALL pulse start during RUN and assert start+abort together in IDLE -> both are ignored, and the sequence and round_idx are unaffected.
